// File: rtl/sar_pkg.sv
// rtl/sar_pkg.sv - shared types and constants for the SAR ADC control logic
package sar_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        CONV   = 2'd2,
        DONE   = 2'd3
    } sar_state_t;

    localparam int SAR_NBITS_DEF         = 10;
    localparam int SAR_SAMPLE_CYCLES_DEF = 4;

    // Width needed to count 0..n-1; never narrower than one bit.
    function automatic int sar_cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sar_ctrl.sv
// rtl/sar_ctrl.sv - successive-approximation FSM, sample timer and result register
module sar_ctrl
    import sar_pkg::*;
#(
    parameter int NBITS         = SAR_NBITS_DEF,
    parameter int SAMPLE_CYCLES = SAR_SAMPLE_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             soc,
    input  logic             cmp,
    output logic             sample,
    output logic             cmp_en,
    output logic [NBITS-1:0] dac_code,
    output logic [NBITS-1:0] data,
    output logic             eoc,
    output logic             busy
);

    localparam int CW = sar_cnt_w(SAMPLE_CYCLES);
    localparam int IW = sar_cnt_w(NBITS);

    localparam logic [CW-1:0]    CNT_LAST = CW'(SAMPLE_CYCLES - 1);
    localparam logic [IW-1:0]    IDX_TOP  = IW'(NBITS - 1);
    localparam logic [NBITS-1:0] MSB_TRY  = {1'b1, {(NBITS-1){1'b0}}};

    sar_state_t       state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [IW-1:0]    idx, idx_n;
    logic             sample_n, cmp_en_n, eoc_n, busy_n;
    logic [NBITS-1:0] dac_n, data_n;

    // Register state and every output so nothing combinational leaves the block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            idx      <= IDX_TOP;
            sample   <= 1'b0;
            cmp_en   <= 1'b0;
            eoc      <= 1'b0;
            busy     <= 1'b0;
            dac_code <= '0;
            data     <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            idx      <= idx_n;
            sample   <= sample_n;
            cmp_en   <= cmp_en_n;
            eoc      <= eoc_n;
            busy     <= busy_n;
            dac_code <= dac_n;
            data     <= data_n;
        end
    end

    // Next-state and next-output decode; a dropped enable overrides everything but data.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        idx_n    = idx;
        sample_n = sample;
        cmp_en_n = cmp_en;
        eoc_n    = 1'b0;
        busy_n   = busy;
        dac_n    = dac_code;
        data_n   = data;

        case (state)
            IDLE: begin
                if (soc && en) begin
                    state_n  = SAMPLE;
                    sample_n = 1'b1;
                    busy_n   = 1'b1;
                    cnt_n    = '0;
                    dac_n    = '0;
                end
            end
            SAMPLE: begin
                cnt_n = cnt + 1'b1;
                if (cnt == CNT_LAST) begin
                    state_n  = CONV;
                    sample_n = 1'b0;
                    cmp_en_n = 1'b1;
                    cnt_n    = '0;
                    dac_n    = MSB_TRY;
                    idx_n    = IDX_TOP;
                end
            end
            CONV: begin
                // Keep the trial bit only if the input is strictly above the DAC level.
                dac_n[idx] = cmp;
                if (idx != '0) begin
                    dac_n[idx - 1'b1] = 1'b1;
                    idx_n             = idx - 1'b1;
                end else begin
                    state_n  = DONE;
                    data_n   = dac_n;
                    eoc_n    = 1'b1;
                    cmp_en_n = 1'b0;
                end
            end
            DONE: begin
                state_n = IDLE;
                busy_n  = 1'b0;
                idx_n   = IDX_TOP;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (!en && state != IDLE) begin
            state_n  = IDLE;
            sample_n = 1'b0;
            cmp_en_n = 1'b0;
            eoc_n    = 1'b0;
            busy_n   = 1'b0;
            dac_n    = '0;
            data_n   = data;
            cnt_n    = '0;
            idx_n    = IDX_TOP;
        end
    end

endmodule
